vga_timing_generator: RTL and testbench
=======================================

Name: vga_timing_generator

Overview:
- Parametrised raster timing generator. Successor to the fixed 640x480 sync pulse generator.
- Explicit front porch, sync and back porch per axis; programmable sync polarity; pixel-clock enable; data-enable output; line/frame start strobes.
- Sits between the system clock domain and the pixel pipeline. Drives the VGA connector syncs and the coordinates used by pixel generators.

Parameters:
H_ACTIVE, 640, visible columns
H_FRONT, 16, horizontal front porch (columns)
H_SYNC, 96, horizontal sync width (columns)
H_BACK, 48, horizontal back porch (columns)
V_ACTIVE, 480, visible rows
V_FRONT, 10, vertical front porch (rows)
V_SYNC, 2, vertical sync width (rows)
V_BACK, 33, vertical back porch (rows)
H_SYNC_POL, 0, asserted level of out_Hsync (0 = active-low)
V_SYNC_POL, 0, asserted level of out_Vsync (0 = active-low)
CNT_WIDTH, 10, width of column_count and row_count

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high; overrides enable
enable  input  1  pixel strobe; counters and phases advance only when 1
out_Hsync  output  1  horizontal sync, polarity per H_SYNC_POL
out_Vsync  output  1  vertical sync, polarity per V_SYNC_POL
out_active  output  1  1 when column < H_ACTIVE and row < V_ACTIVE
column_count  output  CNT_WIDTH  current column, 0..H_TOTAL-1
row_count  output  CNT_WIDTH  current row, 0..V_TOTAL-1
line_start  output  1  one-clock pulse when column wraps to 0
frame_start  output  1  one-clock pulse when (column,row) wraps to (0,0)

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK (default 800).
  - V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK (default 525).
- Elaboration checks (fatal error on violation):
  - every porch, sync and active parameter >= 1;
  - 2^CNT_WIDTH > H_TOTAL-1 and 2^CNT_WIDTH > V_TOTAL-1.
- Registered outputs: every output is a flop. Outputs are mutually consistent in every cycle: syncs, out_active and strobes describe exactly the column_count/row_count presented in the same cycle. Zero skew; no combinational decode on outputs.
- Reset values (on the clock after reset=1):
  - column_count=0, row_count=0;
  - out_active=1;
  - out_Hsync=~H_SYNC_POL, out_Vsync=~V_SYNC_POL;
  - line_start=0, frame_start=0;
  - both phase FSMs = ACTIVE.
- Horizontal phase FSM, states ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE:
  - advance only on enable=1, when column_count is the last column of the current phase;
  - phase boundaries: FRONT starts at column H_ACTIVE, SYNC at H_ACTIVE+H_FRONT, BACK at H_ACTIVE+H_FRONT+H_SYNC;
  - column wraps H_TOTAL-1 -> 0 on enable.
- Vertical phase FSM: same four states with V_* boundaries. Advances only on an enable cycle where the column wraps.
- out_Hsync = H_SYNC_POL while the horizontal FSM is in SYNC, else the inverse. Same rule for out_Vsync with the vertical FSM and V_SYNC_POL.
- out_active = 1 only when both FSMs are in ACTIVE. Strictly column < H_ACTIVE and row < V_ACTIVE; column H_ACTIVE-1 is visible.
- line_start:
  - high for exactly one clock, the clock on which column_count becomes 0 through a wrap;
  - also high on the frame wrap;
  - low in all following cycles even if enable stays low.
- frame_start: high for exactly one clock when the counters become (0,0) through wrap from (H_TOTAL-1, V_TOTAL-1).
- enable=0: counters, FSMs, syncs and out_active hold; strobes drop to 0 after their single cycle.
- Reset mid-frame: next clock returns to the reset values above. No strobe is generated by reset. Normal counting resumes on the next enable.
- No handshake; the block free-runs. Consumers sample coordinates when out_active=1.

Test Plan:
- Defaults, enable tied 1 -> line_start period 800 clocks; out_Hsync=0 exactly for columns 656..751; out_Vsync=0 exactly for rows 490..491; frame_start period 420000 clocks; 307200 out_active cycles per frame.
- Defaults, enable high 1 clock in 4 -> all periods x4; line_start/frame_start exactly 1 clock wide; counters and syncs stable between strobes.
- H_SYNC_POL=1, V_SYNC_POL=1 -> out_Hsync=1 for columns 656..751, else 0; out_Vsync=1 for rows 490..491; out_active unchanged.
- Assert reset for 1 clock at (300,200) -> next clock (0,0), out_active=1, syncs deasserted, frame_start=0; frame_start next fires 420000 enables later.
- Small configuration H=4/1/2/1, V=3/1/1/1, CNT_WIDTH=4 -> exhaustive compare against a reference model over 3 frames, including the wrap at (7,5) -> (0,0) with frame_start=1 and line_start=1 in the same clock.
- Boundary check at defaults -> column 639 out_active=1; column 640 out_active=0; row 479 active; row 480 inactive.

Source files
------------

// File: rtl/vga_timing_generator_if.sv
// Raster timing bundle: pixel strobe in, syncs/coordinates/strobes out.
// The generator owns the master side; pixel pipelines take the slave side.
interface vga_timing_generator_if #(
    parameter int unsigned CNT_WIDTH = 10
);
    logic                 enable;
    logic                 out_Hsync;
    logic                 out_Vsync;
    logic                 out_active;
    logic [CNT_WIDTH-1:0] column_count;
    logic [CNT_WIDTH-1:0] row_count;
    logic                 line_start;
    logic                 frame_start;

    modport master (
        input  enable,
        output out_Hsync,
        output out_Vsync,
        output out_active,
        output column_count,
        output row_count,
        output line_start,
        output frame_start
    );

    modport slave (
        output enable,
        input  out_Hsync,
        input  out_Vsync,
        input  out_active,
        input  column_count,
        input  row_count,
        input  line_start,
        input  frame_start
    );
endinterface

// File: rtl/vga_timing_generator.sv
// Parametrised raster timing generator: per-axis active/front/sync/back phase FSMs,
// column/row counters and registered syncs, data-enable and line/frame strobes.
module vga_timing_generator #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter bit          H_SYNC_POL = 1'b0,
    parameter bit          V_SYNC_POL = 1'b0,
    parameter int unsigned CNT_WIDTH  = 10
) (
    input logic                    clock,
    input logic                    reset,
    vga_timing_generator_if.master bus
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam longint unsigned CNT_SPAN = 64'(1) << CNT_WIDTH;

    if (H_ACTIVE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
        V_ACTIVE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_phase
        $fatal(1, "vga_timing_generator: every active, porch and sync width must be >= 1");
    end

    if (CNT_SPAN <= 64'(H_TOTAL - 1) || CNT_SPAN <= 64'(V_TOTAL - 1)) begin : g_bad_width
        $fatal(1, "vga_timing_generator: CNT_WIDTH too narrow for H_TOTAL/V_TOTAL");
    end

    typedef logic [CNT_WIDTH-1:0] cnt_t;
    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_e;

    // Last coordinate of each phase; the BACK phase ends on the wrap coordinate.
    localparam cnt_t H_ACT_LAST   = cnt_t'(H_ACTIVE - 1);
    localparam cnt_t H_FRONT_LAST = cnt_t'(H_ACTIVE + H_FRONT - 1);
    localparam cnt_t H_SYNC_LAST  = cnt_t'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam cnt_t H_LAST       = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_ACT_LAST   = cnt_t'(V_ACTIVE - 1);
    localparam cnt_t V_FRONT_LAST = cnt_t'(V_ACTIVE + V_FRONT - 1);
    localparam cnt_t V_SYNC_LAST  = cnt_t'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam cnt_t V_LAST       = cnt_t'(V_TOTAL - 1);

    phase_e h_state, h_state_nxt;
    phase_e v_state, v_state_nxt;
    cnt_t   col, col_nxt;
    cnt_t   row, row_nxt;
    logic   h_wrap, v_wrap;
    logic   hsync_q, vsync_q, active_q, line_start_q, frame_start_q;

    // Phase state and counters
    always_ff @(posedge clock) begin
        if (reset) begin
            h_state <= PH_ACTIVE;
            v_state <= PH_ACTIVE;
            col     <= '0;
            row     <= '0;
        end else begin
            h_state <= h_state_nxt;
            v_state <= v_state_nxt;
            col     <= col_nxt;
            row     <= row_nxt;
        end
    end

    // Next phase/coordinate; the vertical axis moves only on a column wrap
    always_comb begin
        h_state_nxt = h_state;
        v_state_nxt = v_state;
        col_nxt     = col;
        row_nxt     = row;
        h_wrap      = 1'b0;
        v_wrap      = 1'b0;
        if (bus.enable) begin
            h_wrap  = (col == H_LAST);
            col_nxt = h_wrap ? '0 : col + cnt_t'(1);
            case (h_state)
                PH_ACTIVE: if (col == H_ACT_LAST)   h_state_nxt = PH_FRONT;
                PH_FRONT:  if (col == H_FRONT_LAST) h_state_nxt = PH_SYNC;
                PH_SYNC:   if (col == H_SYNC_LAST)  h_state_nxt = PH_BACK;
                PH_BACK:   if (h_wrap)              h_state_nxt = PH_ACTIVE;
                default:                            h_state_nxt = PH_ACTIVE;
            endcase
            if (h_wrap) begin
                v_wrap  = (row == V_LAST);
                row_nxt = v_wrap ? '0 : row + cnt_t'(1);
                case (v_state)
                    PH_ACTIVE: if (row == V_ACT_LAST)   v_state_nxt = PH_FRONT;
                    PH_FRONT:  if (row == V_FRONT_LAST) v_state_nxt = PH_SYNC;
                    PH_SYNC:   if (row == V_SYNC_LAST)  v_state_nxt = PH_BACK;
                    PH_BACK:   if (v_wrap)              v_state_nxt = PH_ACTIVE;
                    default:                            v_state_nxt = PH_ACTIVE;
                endcase
            end
        end
    end

    // Decode from next state so every output lines up with the coordinates it sits beside
    always_ff @(posedge clock) begin
        if (reset) begin
            hsync_q       <= ~H_SYNC_POL;
            vsync_q       <= ~V_SYNC_POL;
            active_q      <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= (h_state_nxt == PH_SYNC) ? H_SYNC_POL : ~H_SYNC_POL;
            vsync_q       <= (v_state_nxt == PH_SYNC) ? V_SYNC_POL : ~V_SYNC_POL;
            active_q      <= (h_state_nxt == PH_ACTIVE) && (v_state_nxt == PH_ACTIVE);
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
        end
    end

    assign bus.out_Hsync    = hsync_q;
    assign bus.out_Vsync    = vsync_q;
    assign bus.out_active   = active_q;
    assign bus.column_count = col;
    assign bus.row_count    = row;
    assign bus.line_start   = line_start_q;
    assign bus.frame_start  = frame_start_q;
endmodule

// File: tb/tb_vga_timing_generator.sv
// Three generators (small, inverted-polarity, default 640x480) checked cycle by cycle
// against a coordinate model plus hand-computed periods, counts and boundary points.
module tb_vga_timing_generator;
    localparam int N = 3;
    localparam int CFG_HA   [N] = '{4, 5, 640};
    localparam int CFG_HF   [N] = '{1, 2, 16};
    localparam int CFG_HS   [N] = '{2, 3, 96};
    localparam int CFG_HB   [N] = '{1, 2, 48};
    localparam int CFG_VA   [N] = '{3, 4, 480};
    localparam int CFG_VF   [N] = '{1, 2, 10};
    localparam int CFG_VS   [N] = '{1, 2, 2};
    localparam int CFG_VB   [N] = '{1, 1, 33};
    localparam int CFG_HPOL [N] = '{0, 1, 0};
    localparam int CFG_VPOL [N] = '{0, 1, 0};
    localparam int LS_PERIOD [N] = '{8, 12, 800};
    localparam int FS_PERIOD [N] = '{48, 108, 420000};

    logic clock = 1'b0;
    logic reset;
    logic en [N];

    always #5 clock = ~clock;

    vga_timing_generator_if #(.CNT_WIDTH(4))  if_s ();
    vga_timing_generator_if #(.CNT_WIDTH(4))  if_p ();
    vga_timing_generator_if #(.CNT_WIDTH(10)) if_d ();

    assign if_s.enable = en[0];
    assign if_p.enable = en[1];
    assign if_d.enable = en[2];

    vga_timing_generator #(
        .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CNT_WIDTH(4)
    ) u_small (.clock(clock), .reset(reset), .bus(if_s));

    vga_timing_generator #(
        .H_ACTIVE(5), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CNT_WIDTH(4)
    ) u_pol (.clock(clock), .reset(reset), .bus(if_p));

    vga_timing_generator u_def (.clock(clock), .reset(reset), .bus(if_d));

    int o_col [N], o_row [N], o_hs [N], o_vs [N], o_act [N], o_ls [N], o_fs [N];

    always_comb begin
        o_col[0] = int'(if_s.column_count); o_col[1] = int'(if_p.column_count); o_col[2] = int'(if_d.column_count);
        o_row[0] = int'(if_s.row_count);    o_row[1] = int'(if_p.row_count);    o_row[2] = int'(if_d.row_count);
        o_hs[0]  = int'(if_s.out_Hsync);    o_hs[1]  = int'(if_p.out_Hsync);    o_hs[2]  = int'(if_d.out_Hsync);
        o_vs[0]  = int'(if_s.out_Vsync);    o_vs[1]  = int'(if_p.out_Vsync);    o_vs[2]  = int'(if_d.out_Vsync);
        o_act[0] = int'(if_s.out_active);   o_act[1] = int'(if_p.out_active);   o_act[2] = int'(if_d.out_active);
        o_ls[0]  = int'(if_s.line_start);   o_ls[1]  = int'(if_p.line_start);   o_ls[2]  = int'(if_d.line_start);
        o_fs[0]  = int'(if_s.frame_start);  o_fs[1]  = int'(if_p.frame_start);  o_fs[2]  = int'(if_d.frame_start);
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int m_col [N], m_row [N], m_ls [N], m_fs [N];
    int en_cnt [N], last_ls [N], last_fs [N], n_fs_obs [N], n_fs_mod [N];
    int act_cnt_s, vs_hi_p, hs_low_d;

    function automatic string inst_name(input int i);
        case (i)
            0:       return "small";
            1:       return "pol";
            default: return "def";
        endcase
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference coordinates advance on enable; strobes flag the wrap that produced them
    task automatic model_step(input int i, input bit e);
        int ht, vt;
        bit hw;
        ht = CFG_HA[i] + CFG_HF[i] + CFG_HS[i] + CFG_HB[i];
        vt = CFG_VA[i] + CFG_VF[i] + CFG_VS[i] + CFG_VB[i];
        m_ls[i] = 0;
        m_fs[i] = 0;
        if (e) begin
            hw = (m_col[i] == ht - 1);
            m_ls[i] = int'(hw);
            m_fs[i] = int'(hw && m_row[i] == vt - 1);
            m_col[i] = hw ? 0 : m_col[i] + 1;
            if (hw) m_row[i] = (m_row[i] == vt - 1) ? 0 : m_row[i] + 1;
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            int hs_lo, vs_lo, exp_hs, exp_vs, exp_act;
            hs_lo   = CFG_HA[i] + CFG_HF[i];
            vs_lo   = CFG_VA[i] + CFG_VF[i];
            exp_hs  = (m_col[i] >= hs_lo && m_col[i] < hs_lo + CFG_HS[i]) ? CFG_HPOL[i] : 1 - CFG_HPOL[i];
            exp_vs  = (m_row[i] >= vs_lo && m_row[i] < vs_lo + CFG_VS[i]) ? CFG_VPOL[i] : 1 - CFG_VPOL[i];
            exp_act = int'(m_col[i] < CFG_HA[i] && m_row[i] < CFG_VA[i]);
            check($sformatf("%s column", inst_name(i)), o_col[i], m_col[i]);
            check($sformatf("%s row", inst_name(i)), o_row[i], m_row[i]);
            check($sformatf("%s hsync", inst_name(i)), o_hs[i], exp_hs);
            check($sformatf("%s vsync", inst_name(i)), o_vs[i], exp_vs);
            check($sformatf("%s active", inst_name(i)), o_act[i], exp_act);
            check($sformatf("%s line_start", inst_name(i)), o_ls[i], m_ls[i]);
            check($sformatf("%s frame_start", inst_name(i)), o_fs[i], m_fs[i]);
        end
    endtask

    // Hand-computed periods, per-frame counts and boundary coordinates
    task automatic directed();
        for (int i = 0; i < N; i++) begin
            if (o_ls[i] != 0) begin
                if (last_ls[i] >= 0)
                    check($sformatf("%s line period", inst_name(i)), en_cnt[i] - last_ls[i], LS_PERIOD[i]);
                last_ls[i] = en_cnt[i];
            end
            if (o_fs[i] != 0) begin
                n_fs_obs[i]++;
                if (last_fs[i] >= 0)
                    check($sformatf("%s frame period", inst_name(i)), en_cnt[i] - last_fs[i], FS_PERIOD[i]);
                last_fs[i] = en_cnt[i];
            end
            if (m_fs[i] != 0) n_fs_mod[i]++;
        end
        if (o_fs[0] != 0) begin
            check("small active per frame", act_cnt_s, 12);
            act_cnt_s = 0;
        end
        if (en[0] && o_act[0] != 0) act_cnt_s++;
        if (o_fs[1] != 0) begin
            check("pol vsync high per frame", vs_hi_p, 24);
            vs_hi_p = 0;
        end
        if (en[1] && o_vs[1] != 0) vs_hi_p++;
        if (o_ls[2] != 0) begin
            check("def hsync low per line", hs_low_d, 96);
            hs_low_d = 0;
        end
        if (en[2] && o_hs[2] == 0) hs_low_d++;

        if (en[0] && m_col[0] == 3 && m_row[0] == 2) check("small col3 row2 active", o_act[0], 1);
        if (en[0] && m_col[0] == 4 && m_row[0] == 2) check("small col4 row2 active", o_act[0], 0);
        if (en[0] && m_col[0] == 0 && m_row[0] == 3) check("small row3 active", o_act[0], 0);
        if (en[0] && m_col[0] == 7 && m_row[0] == 5) check("small last pixel frame_start", o_fs[0], 0);
        if (m_fs[0] != 0) begin
            check("small wrap column", o_col[0], 0);
            check("small wrap row", o_row[0], 0);
            check("small wrap line_start", o_ls[0], 1);
            check("small wrap frame_start", o_fs[0], 1);
        end
        if (en[1] && m_col[1] == 7)  check("pol col7 hsync", o_hs[1], 1);
        if (en[1] && m_col[1] == 10) check("pol col10 hsync", o_hs[1], 0);
        if (en[1] && m_col[1] == 0 && m_row[1] == 6) check("pol row6 vsync", o_vs[1], 1);
        if (en[1] && m_col[1] == 0 && m_row[1] == 8) check("pol row8 vsync", o_vs[1], 0);
        if (en[1] && m_col[1] == 4 && m_row[1] == 3) check("pol col4 row3 active", o_act[1], 1);
        if (en[2] && m_col[2] == 639) check("def col639 active", o_act[2], 1);
        if (en[2] && m_col[2] == 640) check("def col640 active", o_act[2], 0);
        if (en[2] && m_col[2] == 655) check("def col655 hsync", o_hs[2], 1);
        if (en[2] && m_col[2] == 656) check("def col656 hsync", o_hs[2], 0);
        if (en[2] && m_col[2] == 751) check("def col751 hsync", o_hs[2], 0);
        if (en[2] && m_col[2] == 752) check("def col752 hsync", o_hs[2], 1);
    endtask

    task automatic tick(input bit e0, input bit e1, input bit e2);
        en[0] = e0;
        en[1] = e1;
        en[2] = e2;
        @(posedge clock);
        #1;
        cyc++;
        model_step(0, e0);
        model_step(1, e1);
        model_step(2, e2);
        for (int i = 0; i < N; i++) if (en[i]) en_cnt[i]++;
        compare_all();
        directed();
    endtask

    task automatic pulse_reset(input bit e);
        reset = 1'b1;
        for (int i = 0; i < N; i++) en[i] = e;
        @(posedge clock);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            m_col[i]   = 0;
            m_row[i]   = 0;
            m_ls[i]    = 0;
            m_fs[i]    = 0;
            last_ls[i] = en_cnt[i];
            last_fs[i] = en_cnt[i];
        end
        act_cnt_s = 1;
        vs_hi_p   = 0;
        hs_low_d  = 0;
        compare_all();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            en[i] = 1'b0;
            m_col[i] = 0; m_row[i] = 0; m_ls[i] = 0; m_fs[i] = 0;
            en_cnt[i] = 0; last_ls[i] = -1; last_fs[i] = -1;
            n_fs_obs[i] = 0; n_fs_mod[i] = 0;
        end
        act_cnt_s = 0;
        vs_hi_p   = 0;
        hs_low_d  = 0;

        pulse_reset(1'b0);
        pulse_reset(1'b1);

        // Enable tied high: two full default lines, many small frames
        for (int k = 0; k < 1700; k++) tick(1'b1, 1'b1, 1'b1);

        // Pixel strobe one clock in four
        for (int k = 0; k < 800; k++) tick(k % 4 == 0, k % 4 == 0, k % 4 == 0);

        // Reset mid-frame at small (3,2), enable held high through reset
        for (int k = 0; k < 100 && !(m_col[0] == 3 && m_row[0] == 2); k++) tick(1'b1, 1'b1, 1'b1);
        pulse_reset(1'b1);
        check("reset mid-frame line_start", o_ls[0], 0);
        for (int k = 0; k < 60; k++) tick(1'b1, 1'b1, 1'b1);

        for (int i = 0; i < N; i++)
            check($sformatf("%s frame_start count", inst_name(i)), n_fs_obs[i], n_fs_mod[i]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
